// File: rtl/uart_tx_streamer.sv
// uart_tx_streamer: drains an upstream character FIFO out of a UART serial line, one frame per character.
module uart_tx_streamer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_SIZE    = 8
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 start_send,
  input  logic [DATA_SIZE-1:0] fifo_data_in,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           byte_count
);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, ADVANCE, SETTLE} state_t;
  localparam int IW = DATA_SIZE > 1 ? $clog2(DATA_SIZE) : 1;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] TOP = IW'(DATA_SIZE - 1);
  state_t               state_q;
  logic [15:0]          timer_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_SIZE-1:0] sh_q;
  logic                 tx_q;
  logic [3:0]           cnt_q;
  logic                 bit_end;
  assign bit_end    = timer_q == LAST;
  assign tx         = tx_q;
  assign busy       = state_q != IDLE;
  assign fifo_read  = state_q == ADVANCE;
  // fifo_empty already reflects the ADVANCE read while in SETTLE
  assign done       = state_q == SETTLE && fifo_empty;
  assign byte_count = cnt_q;
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      timer_q <= (state_q inside {START, DATA, STOP}) && !bit_end ? timer_q + 16'd1 : 16'd0;
      case (state_q)
        IDLE:
          if (start_send && !fifo_empty) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end
        LOAD: begin
          sh_q    <= fifo_data_in;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START:
          if (bit_end) begin
            idx_q   <= '0;
            tx_q    <= sh_q[0];
            state_q <= DATA;
          end
        DATA:
          if (bit_end) begin
            if (idx_q == TOP) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + IW'(1);
              tx_q  <= sh_q[1];
              sh_q  <= sh_q >> 1;
            end
          end
        STOP:
          if (bit_end) begin
            cnt_q   <= cnt_q == 4'hF ? cnt_q : cnt_q + 4'd1;
            state_q <= ADVANCE;
          end
        ADVANCE: state_q <= SETTLE;
        SETTLE:  state_q <= fifo_empty ? IDLE : LOAD;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_streamer.sv
// tb_uart_tx_streamer: directed stimulus with a FIFO model; a serial-line monitor decodes frames against an expected-byte queue.
module tb_uart_tx_streamer;
  localparam int CPB = 4;
  logic       clk = 0;
  logic       reset;
  logic       start_send;
  logic [7:0] fifo_data_in;
  logic       fifo_empty;
  logic       fifo_read, tx, busy, done;
  logic [3:0] byte_count;
  logic [7:0] mem [16];
  int         rd, len;
  logic [7:0] exp_q [$];
  int         checks = 0, failures = 0;
  int         rd_cnt = 0, done_cnt = 0, rx_frames = 0, cyc = 0, last_rd = 0, done_cyc = 0;
  int         ph = -1, hi = 0;
  bit         armed = 0;
  logic [7:0] rx;

  uart_tx_streamer #(.CLKS_PER_BIT(CPB), .DATA_SIZE(8)) dut (
    .clk_100MHz(clk), .reset(reset), .start_send(start_send), .fifo_data_in(fifo_data_in),
    .fifo_empty(fifo_empty), .fifo_read(fifo_read), .tx(tx), .busy(busy), .done(done),
    .byte_count(byte_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign fifo_data_in = mem[rd[3:0]];
  assign fifo_empty   = rd >= len;
  // FIFO pointer moves mid-ADVANCE, well clear of any edge where the DUT samples it
  always @(negedge clk) if (fifo_read) rd++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load(input string s, input bit push);
    for (int i = 0; i < s.len(); i++) begin
      mem[i] = s[i];
      if (push) exp_q.push_back(s[i]);
    end
    rd = 0;
    len = s.len();
  endtask

  task automatic pulse_start();
    @(negedge clk) start_send = 1;
    @(posedge clk);
    #1 start_send = 0;
  endtask

  task automatic wait_done(input int max);
    bit got = 0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic idle_window(input string name);
    bit bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0 || done !== 1'b0) bad = 1;
    end
    chk(name, bad, 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      ph = -1;
      armed = 0;
    end else begin
      if (fifo_read) begin
        rd_cnt++;
        last_rd = cyc;
        chk("read_with_done", done, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        armed = 0;
      end
      if (ph < 0) begin
        if (!tx) begin
          if (armed) chk("frame_gap", hi, 3);
          ph = 0;
        end else hi++;
      end else begin
        ph++;
        if (ph == CPB / 2) chk("start_bit", tx, 0);
        if (ph >= CPB && ph < 9 * CPB && ph % CPB == CPB / 2) rx[ph / CPB - 1] = tx;
        if (ph == 9 * CPB + CPB / 2) begin
          chk("stop_bit", tx, 1);
          rx_frames++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%0h expected=none", rx);
          end else chk("frame_data", rx, exp_q.pop_front());
        end
        if (ph == 10 * CPB - 1) begin
          ph = -1;
          hi = 0;
          armed = 1;
        end
      end
    end
  end

  initial begin
    reset = 1;
    start_send = 0;
    rd = 0;
    len = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_read", fifo_read, 0);
    chk("rst_done", done, 0);
    chk("rst_count", byte_count, 0);
    @(negedge clk) reset = 0;

    load("SIMONSAY", 1);
    rd_cnt = 0; done_cnt = 0; rx_frames = 0;
    pulse_start();
    chk("load_busy", busy, 1);
    chk("load_tx", tx, 1);
    @(posedge clk);
    #1 chk("start_tx_low", tx, 0);
    repeat (50) @(posedge clk);
    @(negedge clk) start_send = 1;
    @(negedge clk) start_send = 0;
    wait_done(1000);
    repeat (5) @(negedge clk);
    chk("msg_count", byte_count, 8);
    chk("msg_reads", rd_cnt, 8);
    chk("msg_dones", done_cnt, 1);
    chk("msg_frames", rx_frames, 8);
    chk("msg_queue", exp_q.size(), 0);

    len = rd;
    rd_cnt = 0; done_cnt = 0; rx_frames = 0;
    pulse_start();
    idle_window("empty_idle");
    chk("empty_reads", rd_cnt, 0);
    chk("empty_frames", rx_frames, 0);
    chk("empty_count", byte_count, 8);

    load("SIMONSAY", 0);
    rd_cnt = 0; done_cnt = 0;
    pulse_start();
    repeat (18) @(posedge clk);
    #2 chk("bit3_tx", tx, 0);
    chk("bit3_busy", busy, 1);
    reset = 1;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_count", byte_count, 0);
    @(negedge clk) reset = 0;
    idle_window("post_reset_idle");
    chk("abort_reads", rd_cnt, 0);

    load("ABC", 1);
    rd_cnt = 0; done_cnt = 0; rx_frames = 0;
    pulse_start();
    @(posedge clk);
    #1 mem[0] = 8'hFF;
    wait_done(1000);
    repeat (3) @(negedge clk);
    chk("short_count", byte_count, 3);
    chk("short_reads", rd_cnt, 3);
    chk("short_dones", done_cnt, 1);
    chk("short_frames", rx_frames, 3);
    chk("done_after_read", done_cyc - last_rd, 1);
    chk("short_queue", exp_q.size(), 0);
    chk("short_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_streamer.md
UART_TX_STREAMER -- requirements
Module: uart_tx_streamer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter DATA_SIZE, default 8, bits per character.
REQ-003 clk_100MHz  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_send  input  1  request to transmit the buffered message; sampled only in IDLE.
REQ-006 fifo_data_in  input  DATA_SIZE  current character from the upstream character FIFO (combinational there).
REQ-007 fifo_empty  input  1  upstream FIFO has no unread character.
REQ-008 fifo_read  output  1  one-cycle pulse advancing the upstream FIFO read pointer.
REQ-009 tx  output  1  registered UART serial line, idle high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when the message is finished.
REQ-012 byte_count  output  4  characters fully transmitted since the last accepted start_send.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, START, DATA, STOP, ADVANCE, SETTLE.
REQ-014 IDLE: if start_send=1 and fifo_empty=0 go to LOAD and clear byte_count; otherwise stay.
REQ-015 LOAD (1 cycle): latch fifo_data_in into the shift register, clear the bit timer, go to START.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-017 DATA: tx=shift register bit[index], LSB first, each bit held CLKS_PER_BIT cycles; after bit DATA_SIZE-1 go to STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles, then go to ADVANCE and increment byte_count, saturating at 15.
REQ-019 ADVANCE (1 cycle): fifo_read=1, tx=1, go to SETTLE.
REQ-020 SETTLE (1 cycle): fifo_read=0; if fifo_empty=1, pulse done and go to IDLE; else go to LOAD.
REQ-021 fifo_read SHALL be asserted only in ADVANCE, never twice per character.
REQ-022 Frame length SHALL be 10*CLKS_PER_BIT cycles; gap between consecutive frames (tx high) SHALL be 3 cycles (ADVANCE, SETTLE, LOAD).
REQ-023 tx SHALL go low in the first cycle of START, 2 cycles after the edge that samples start_send.
REQ-024 start_send while busy=1 SHALL be ignored, with no effect on count or sequence.
REQ-025 start_send with fifo_empty=1 SHALL be ignored: no fifo_read, no done, tx stays 1.
REQ-026 A change of fifo_data_in after LOAD SHALL NOT alter the frame in progress.
REQ-027 Bit timer SHALL be 16 bits, counting 0..CLKS_PER_BIT-1 and wrapping at each bit boundary.
REQ-028 done and fifo_read SHALL never be high in the same cycle.

Reset
REQ-029 While reset=1, outputs SHALL be, immediately and independent of the clock: state IDLE, tx=1, busy=0, fifo_read=0, done=0, byte_count=0, timer and bit index 0.
REQ-030 Reset mid-frame SHALL abort the frame; after release the block SHALL stay in IDLE until a new start_send.

Verification (bench CLKS_PER_BIT=4)
REQ-031 Reset pulse -> tx=1, busy=0, fifo_read=0, done=0, byte_count=0 within the same cycle.
REQ-032 FIFO model loaded with "SIMONSAY" (0x53 first), start_send -> 8 frames of 40 cycles with 3-cycle gaps; first frame bits 0,1,1,0,0,1,0,1,0,1; 8 fifo_read pulses; one done pulse; byte_count=8.
REQ-033 start_send with fifo_empty=1 -> tx stays 1, busy=0, no fifo_read, no done for 100 cycles.
REQ-034 start_send re-pulsed during frame 2 -> ignored; sequence and byte_count=8 unchanged.
REQ-035 reset asserted during DATA bit 3 of frame 1 -> tx=1, busy=0 in the same cycle; no activity after release until a new start_send.
REQ-036 FIFO model reports empty after its 3rd read -> exactly 3 frames, done in the SETTLE following the 3rd ADVANCE, byte_count=3.
